// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, row drive
// patterns and the column-pattern helpers used by the scan FSM.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] ROW0     = 4'b1110;
    localparam logic [3:0] ROW1     = 4'b1101;
    localparam logic [3:0] ROW2     = 4'b1011;
    localparam logic [3:0] ROW3     = 4'b0111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // True when exactly one column line is pulled low.
    function automatic logic single_col(input logic [3:0] c);
        logic hit;
        case (c)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin/consumer side bundle of the keypad scanner: column sense in, row drive
// and decoded key results out.
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output col,
        input  row,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner_keypad.sv
// Combinational row/column to key-code decoder for the 4x4 keypad; both inputs
// are active-low one-hot, any other combination decodes to 4'h0.
module keypad (
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    output logic [3:0] key_o
);

    // Row/column lookup table.
    always_comb begin
        key_o = 4'h0;
        case ({row_i, col_i})
            8'b1110_1110: key_o = 4'h1;
            8'b1110_1101: key_o = 4'h2;
            8'b1110_1011: key_o = 4'h3;
            8'b1110_0111: key_o = 4'hA;
            8'b1101_1110: key_o = 4'h4;
            8'b1101_1101: key_o = 4'h5;
            8'b1101_1011: key_o = 4'h6;
            8'b1101_0111: key_o = 4'hB;
            8'b1011_1110: key_o = 4'h7;
            8'b1011_1101: key_o = 4'h8;
            8'b1011_1011: key_o = 4'h9;
            8'b1011_0111: key_o = 4'hC;
            8'b0111_1110: key_o = 4'hE;
            8'b0111_1101: key_o = 4'h0;
            8'b0111_1011: key_o = 4'hF;
            8'b0111_0111: key_o = 4'hD;
            default:      key_o = 4'h0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// Sequential 4x4 keypad front end: rotates the row drive, synchronises and
// debounces the columns, and emits one key_valid strobe per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0]       sync1_q;
    logic [3:0]       col_s_q;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       row_q,       row_d;
    logic [3:0]       cand_q,      cand_d;
    logic [3:0]       key_q,       key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q,  key_held_d;
    logic [3:0]       dec_key_s;

    keypad u_keypad (
        .row_i (row_q),
        .col_i (cand_q),
        .key_o (dec_key_s)
    );

    // Two-flop synchroniser for the asynchronous column lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= COL_IDLE;
            col_s_q <= COL_IDLE;
        end else begin
            sync1_q <= kp.col;
            col_s_q <= sync1_q;
        end
    end

    // Scan/debounce next-state logic; the counter restarts on every state change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (single_col(col_s_q)) begin
                        state_d = DB_PRESS;
                        cand_d  = col_s_q;
                    end else begin
                        row_d = next_row(row_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_PRESS: begin
                if (col_s_q != cand_q) begin
                    state_d = SCAN;
                    row_d   = next_row(row_q);
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    key_d       = dec_key_s;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    cnt_d       = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                // Extra keys on the frozen row are ignored until full release.
                if (col_s_q == COL_IDLE) begin
                    state_d = DB_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            DB_RELEASE: begin
                if (col_s_q != COL_IDLE) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d    = SCAN;
                    row_d      = next_row(row_q);
                    key_held_d = 1'b0;
                    cnt_d      = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = SCAN;
                row_d      = ROW0;
                cnt_d      = CNT_ZERO;
                key_held_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            cnt_q       <= CNT_ZERO;
            row_q       <= ROW0;
            cand_q      <= COL_IDLE;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a key-matrix model drives the columns
// from the row drive and a set of pressed keys; strobes are compared to a table.
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DB = 8;

    localparam logic [3:0] ROWS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Key index = row*4 + column.
    localparam logic [3:0] CODE [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = 16'h0000;
    logic        force_high = 1'b0;
    logic [3:0]  col_drv;
    logic [3:0]  strobes [$];
    int          kv_double = 0;
    logic        kv_prev = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its column low while its row is driven.
    always_comb begin
        col_drv = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.row[r]) col_drv[c] = 1'b0;
        if (force_high) col_drv = 4'b1111;
    end
    assign kif.col = col_drv;

    // Strobe recorder, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (kif.key_valid) begin
            strobes.push_back(kif.key);
            if (kv_prev) kv_double <= kv_double + 1;
        end
        kv_prev <= kif.key_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench just after the reset edge (cycle 0 of the timeline).
    task automatic do_reset();
        pressed    = 16'h0000;
        force_high = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        strobes.delete();
    endtask

    initial begin
        int perm [16];
        int idx2;
        int n0;

        // 1. Reset values and idle rotation.
        do_reset();
        check_eq("rst_row", kif.row, 4'b1110);
        check_eq("rst_key", kif.key, 4'h0);
        check_eq("rst_kv", kif.key_valid, 1'b0);
        check_eq("rst_kh", kif.key_held, 1'b0);
        for (int k = 1; k < 20; k++) begin
            adv(1);
            check_eq("idle_row", kif.row, ROWS[(k / SC) % 4]);
        end
        check_eq("idle_strobes", strobes.size(), 0);
        check_eq("idle_key", kif.key, 4'h0);

        // Press latency: key 2 seen at the end of the first row slot (edge 4), strobe DB edges later.
        do_reset();
        pressed = 16'h0002;
        adv(SC + DB - 1);
        check_eq("lat_kv_early", kif.key_valid, 1'b0);
        adv(1);
        check_eq("lat_kv", kif.key_valid, 1'b1);
        check_eq("lat_key", kif.key, 4'h2);
        check_eq("lat_kh", kif.key_held, 1'b1);
        adv(1);
        check_eq("lat_kv_fall", kif.key_valid, 1'b0);
        check_eq("lat_kh_hold", kif.key_held, 1'b1);
        pressed = 16'h0000;
        adv(30);
        check_eq("lat_kh_rel", kif.key_held, 1'b0);
        check_eq("lat_strobes", strobes.size(), 1);

        // 2. Full sweep in random order with random hold times.
        do_reset();
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            n0 = strobes.size();
            pressed = 16'h0001 << perm[i];
            adv(int'($urandom_range(80, 40)));
            check_eq("sweep_held", kif.key_held, 1'b1);
            pressed = 16'h0000;
            adv(30);
            check_eq("sweep_released", kif.key_held, 1'b0);
            check_eq("sweep_count", strobes.size() - n0, 1);
            if (strobes.size() > n0) check_eq("sweep_code", strobes[n0], CODE[perm[i]]);
            check_eq("sweep_key_hold", kif.key, CODE[perm[i]]);
        end

        // 3. Press bounce on key 9: row 2 slot ends at edge 12, release after 3 cycles.
        do_reset();
        adv(9);
        pressed = 16'h0400;
        adv(3);
        pressed = 16'h0000;
        check_eq("pb_row_frozen12", kif.row, 4'b1011);
        adv(2);
        check_eq("pb_row_frozen14", kif.row, 4'b1011);
        adv(1);
        check_eq("pb_row3", kif.row, 4'b0111);
        adv(3);
        check_eq("pb_row3_slot", kif.row, 4'b0111);
        adv(1);
        check_eq("pb_row0", kif.row, 4'b1110);
        adv(20);
        check_eq("pb_strobes", strobes.size(), 0);

        // 4. Release bounce on key 1.
        do_reset();
        pressed = 16'h0001;
        adv(20);
        force_high = 1'b1;
        adv(3);
        force_high = 1'b0;
        check_eq("rb_held_bounce", kif.key_held, 1'b1);
        adv(17);
        pressed = 16'h0000;
        check_eq("rb_strobes", strobes.size(), 1);
        if (strobes.size() > 0) check_eq("rb_code", strobes[0], 4'h1);
        // 2 synchroniser edges + 1 edge into release debounce + DB edges.
        adv(2 + DB);
        check_eq("rb_held_late", kif.key_held, 1'b1);
        adv(1);
        check_eq("rb_held_fall", kif.key_held, 1'b0);
        check_eq("rb_next_row", kif.row, 4'b1101);
        adv(20);
        check_eq("rb_strobes_end", strobes.size(), 1);

        // 5. Rollover: key 1, then a random key on rows 1..3 while 1 is held.
        do_reset();
        idx2 = 4 + int'($urandom_range(11, 0));
        pressed = 16'h0001;
        adv(SC + DB);
        check_eq("ro_kv1", kif.key_valid, 1'b1);
        check_eq("ro_key1", kif.key, 4'h1);
        adv(8);
        pressed = pressed | (16'h0001 << idx2);
        adv(10);
        pressed = 16'h0001 << idx2;
        check_eq("ro_no_second", strobes.size(), 1);
        adv(2 + DB);
        check_eq("ro_held_late", kif.key_held, 1'b1);
        check_eq("ro_still_one", strobes.size(), 1);
        adv(1);
        check_eq("ro_held_fall", kif.key_held, 1'b0);
        adv(40);
        check_eq("ro_count", strobes.size(), 2);
        if (strobes.size() > 1) check_eq("ro_code2", strobes[1], CODE[idx2]);
        check_eq("ro_key2", kif.key, CODE[idx2]);
        check_eq("ro_held2", kif.key_held, 1'b1);
        pressed = 16'h0000;
        adv(30);

        // 6. Reset at cnt=4 in press debounce (entered at edge 4).
        do_reset();
        pressed = 16'h0002;
        adv(SC + 4);
        reset = 1'b1;
        pressed = 16'h0000;
        adv(1);
        check_eq("mr_row", kif.row, 4'b1110);
        check_eq("mr_kh", kif.key_held, 1'b0);
        check_eq("mr_kv", kif.key_valid, 1'b0);
        reset = 1'b0;
        adv(30);
        check_eq("mr_strobes", strobes.size(), 0);
        check_eq("mr_key", kif.key, 4'h0);

        check_eq("kv_single_cycle", kv_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
